// File: rtl/pc_redirect_if.sv
// Instruction-fetch request channel: valid/ready handshake carrying the fetch address.
// The master holds fetch_pc stable from the first valid cycle until ready is seen.
interface pc_redirect_if;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_pc;

    modport master (output fetch_valid, output fetch_pc, input fetch_ready);
    modport slave  (input fetch_valid, input fetch_pc, output fetch_ready);
endinterface

// File: rtl/pc_redirect.sv
// Fetch PC generator with control-flow/trap redirect, pending-redirect buffering and link/exception outputs.
// Optional feature: define RV_COMPRESSED_EN for halfword-aligned targets and +2 links.
module pc_redirect #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                dec_valid,
    input  logic                stall,
    input  logic [31:0]         dec_pc,
    input  logic                branch,
    input  logic                branch_taken,
    input  logic                jal,
    input  logic                jalr,
    input  logic                comp_sig,
    input  logic [31:0]         branoff,
    input  logic                trap,
    input  logic [31:0]         trap_vec,
    pc_redirect_if.master       fetch,
    output logic                flush,
    output logic [31:0]         link_addr,
    output logic                misalign_exc,
    output logic [31:0]         exc_addr
);

    typedef enum logic [1:0] {StIdle, StRun, StPend} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic        valid_q;

    logic        cf_req;
    logic        is_jump;
    logic [31:0] target;
    logic        aligned;
    logic [31:0] link_off;
    logic        redir;
    logic [31:0] redir_tgt;

    assign is_jump = jal | jalr;
    assign cf_req  = dec_valid & ~stall & (is_jump | (branch & branch_taken));
    assign target  = jalr ? {branoff[31:1], 1'b0} : dec_pc + branoff;

`ifdef RV_COMPRESSED_EN
    assign aligned  = ~target[0];
    assign link_off = comp_sig ? 32'd2 : 32'd4;
`else
    logic unused_comp_sig;
    assign unused_comp_sig = comp_sig;
    assign aligned  = (target[1:0] == 2'b00);
    assign link_off = 32'd4;
`endif

    // Trap has priority over any control-flow redirect.
    assign redir     = trap | (cf_req & aligned);
    assign redir_tgt = trap ? trap_vec : target;

    assign flush             = redir | ((state_q == StPend) & fetch.fetch_ready);
    assign fetch.fetch_valid = valid_q;
    assign fetch.fetch_pc    = pc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            pc_q         <= RESET_PC;
            pend_q       <= 32'h0;
            valid_q      <= 1'b0;
            link_addr    <= 32'h0;
            misalign_exc <= 1'b0;
            exc_addr     <= 32'h0;
        end else begin
            if (cf_req && is_jump) begin
                link_addr <= dec_pc + link_off;
            end
            misalign_exc <= cf_req & ~aligned;
            if (cf_req && !aligned) begin
                exc_addr <= target;
            end

            unique case (state_q)
                StIdle: begin
                    state_q <= StRun;
                    valid_q <= 1'b1;
                end
                StRun: begin
                    if (fetch.fetch_ready) begin
                        pc_q <= redir ? redir_tgt : pc_q + 32'd4;
                    end else if (redir) begin
                        // Request is held: park the redirect until the current address is taken.
                        pend_q  <= redir_tgt;
                        state_q <= StPend;
                    end
                end
                StPend: begin
                    if (fetch.fetch_ready) begin
                        pc_q    <= redir ? redir_tgt : pend_q;
                        state_q <= StRun;
                    end else if (redir) begin
                        pend_q <= redir_tgt;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_redirect.md
# pc_redirect

Fetch-side PC generator and control-flow redirect unit. It consumes the branch/jump offset from the decode stage and the decoded control-flow flags, and computes the taken target. It owns the fetch PC register and drives a valid/ready request to instruction memory, buffering a redirect when a request is held. It emits the link address, the IF/ID flush, and misaligned-target exceptions.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dec_valid  in  1  decode holds a valid instruction
- stall  in  1  pipeline stall; decode-side inputs ignored while high
- dec_pc  in  32  PC of the decode instruction
- branch  in  1  B-type instruction
- branch_taken  in  1  comparator result; meaningful only with branch
- jal, jalr  in  1 each  jump flags; mutually exclusive with branch
- comp_sig  in  1  decode instruction is 16-bit
- branoff  in  32  PC offset (B/JAL) or absolute rs1+imm (JALR)
- trap  in  1  trap redirect request
- trap_vec  in  32  trap handler address
- fetch_ready  in  1  imem accepts request
- fetch_valid  out  1  request valid
- fetch_pc  out  32  request address
- flush  out  1  kill the IF/ID instruction
- link_addr  out  32  registered return address for JAL/JALR
- misalign_exc  out  1  one-cycle pulse, registered
- exc_addr  out  32  faulting target, valid with misalign_exc

## Operation
- cf_req = dec_valid & ~stall & (jal | jalr | (branch & branch_taken)).
- Target: JAL/branch = dec_pc + branoff, mod 2^32. JALR = {branoff[31:1],1'b0}.
- link_addr <= dec_pc + (comp_sig ? 2 : 4) on every cycle where jal|jalr is qualified by cf_req. Otherwise it holds.
- A misaligned target (see Configuration) produces no redirect and no flush. It sets misalign_exc=1 and exc_addr=target on the next cycle.
- redir = trap | (cf_req & aligned). redir_tgt = trap ? trap_vec : target. Trap always wins over a control-flow redirect.
- FSM states are IDLE, RUN and PEND.
  - IDLE: fetch_valid=0. Always goes to RUN next cycle.
  - RUN: fetch_valid=1, fetch_pc=pc_q.
    - fetch_ready & ~redir: pc_q <= pc_q+4.
    - fetch_ready & redir: pc_q <= redir_tgt.
    - ~fetch_ready & redir: pend_q <= redir_tgt and go to PEND. pc_q holds.
  - PEND: fetch_valid=1, fetch_pc=pc_q (held stable).
    - A new redir overwrites pend_q.
    - On fetch_ready: pc_q <= (redir ? redir_tgt : pend_q), flush=1, go to RUN.
- flush is combinational: 1 whenever redir is asserted, and on the PEND accept cycle.
- Handshake: once fetch_valid=1, fetch_pc must not change until fetch_ready is sampled high.

## Timing
- Reset values: state=IDLE, pc_q=RESET_PC, pend_q=0, fetch_valid=0, fetch_pc=RESET_PC, flush=0, link_addr=0, misalign_exc=0, exc_addr=0.
- First request: the first rising edge after rst_n deasserts moves to RUN. fetch_valid=1 with RESET_PC is visible on the following cycle.
- Redirect latency: 1 cycle (redir with fetch_ready at edge N gives fetch_pc=target after N). A held request adds the cycles until accept.
- misalign_exc and link_addr are valid 1 cycle after cf_req.
- stall=1 suppresses cf_req only. Trap and fetch sequencing continue.
- Reset mid-PEND discards pend_q and returns to IDLE immediately.
- pc_q+4 wraps from 32'hFFFF_FFFC to 0.

## Configuration
- RV_COMPRESSED_EN defined:
  - A target is aligned when bit0=0. Bit1 set is legal.
  - fetch_pc carries the full halfword address.
  - comp_sig selects the +2 link offset.
- RV_COMPRESSED_EN undefined:
  - A target is aligned only when bits[1:0]=0. target[1]=1 raises misalign_exc.
  - comp_sig is ignored and the link offset is always +4.
  - JALR still clears bit0 before the check.

## Test plan
- Reset release with RESET_PC=32'h100 and fetch_ready=1 -> fetch_pc sequence 100,104,108; flush=0 throughout.
- JAL with dec_pc=32'h200, branoff=32'hFFFF_FFF0, fetch_ready=1 -> flush=1 that cycle; next fetch_pc=32'h1F0; link_addr=32'h204.
- Taken branch to 32'h400 while fetch_ready=0 for 3 cycles -> fetch_pc held at old value; on accept flush=1; next fetch_pc=32'h400.
- trap (trap_vec=32'h80) and taken JAL in the same cycle -> next fetch_pc=32'h80; link_addr still updated for the JAL.
- Without RV_COMPRESSED_EN, JALR with branoff=32'h302 -> no redirect; next cycle misalign_exc=1, exc_addr=32'h302. With the macro defined -> fetch_pc=32'h302.
- stall=1 with a taken branch -> no flush and the PC advances sequentially. Asserting rst_n=0 in PEND -> fetch_valid=0 and pc_q=RESET_PC immediately.
